// File: rtl/branch_predictor_if.sv
// Interface bundling the fetch-side prediction port, the execute-side
// resolution/training port and the statistics outputs of the branch predictor.
interface branch_predictor_if;

   // Fetch-stage lookup
   logic [31:0] pc_f;
   logic        pred_taken_f;
   logic [31:0] pred_target_f;

   // Execute-stage resolution and training
   logic        update_e;
   logic [31:0] pc_e;
   logic        branch_taken_e;
   logic [31:0] target_e;
   logic        pred_taken_e;
   logic [31:0] pred_target_e;
   logic        mispredict_e;

   // Statistics
   logic [31:0] branch_count;
   logic [31:0] miss_count;

   // The pipeline side drives PCs and resolved outcomes, and consumes predictions
   modport master (
      output pc_f,
      output update_e,
      output pc_e,
      output branch_taken_e,
      output target_e,
      output pred_taken_e,
      output pred_target_e,
      input  pred_taken_f,
      input  pred_target_f,
      input  mispredict_e,
      input  branch_count,
      input  miss_count
   );

   // The predictor side
   modport slave (
      input  pc_f,
      input  update_e,
      input  pc_e,
      input  branch_taken_e,
      input  target_e,
      input  pred_taken_e,
      input  pred_target_e,
      output pred_taken_f,
      output pred_target_f,
      output mispredict_e,
      output branch_count,
      output miss_count
   );

endinterface

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: a bimodal table of 2-bit saturating counters
// combined with a direct-mapped branch target buffer. Lookups are purely
// combinational from the fetch PC; training happens on the clock edge when the
// execute stage resolves a conditional branch. Counter encoding:
// 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
module branch_predictor #(
   parameter int INDEX_BITS = 6
) (
   input logic              clk,
   input logic              rst,
   branch_predictor_if.slave bp
);

   localparam int TAG_BITS = 30 - INDEX_BITS;
   localparam int ENTRIES  = 1 << INDEX_BITS;

   localparam logic [1:0] CTR_WEAK_NOT_TAKEN = 2'b01;
   localparam logic [1:0] CTR_WEAK_TAKEN     = 2'b10;
   localparam logic [1:0] CTR_STRONG_TAKEN   = 2'b11;
   localparam logic [1:0] CTR_STRONG_NOT     = 2'b00;

   localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

   // Table storage, all in flops so the combinational read needs no RAM
   logic                valid_q  [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];

   logic [31:0] branch_count_q;
   logic [31:0] miss_count_q;

   logic [INDEX_BITS-1:0] index_f;
   logic [TAG_BITS-1:0]   tag_f;
   logic [INDEX_BITS-1:0] index_e;
   logic [TAG_BITS-1:0]   tag_e;

   logic       hit_e;
   logic       mispredict;
   logic [1:0] ctr_next;

   // The low two PC bits are always zero for aligned instructions
   logic unused_pc_bits;
   assign unused_pc_bits = ^{bp.pc_f[1:0], bp.pc_e[1:0]};

   assign index_f = bp.pc_f[INDEX_BITS+1:2];
   assign tag_f   = bp.pc_f[31:INDEX_BITS+2];
   assign index_e = bp.pc_e[INDEX_BITS+1:2];
   assign tag_e   = bp.pc_e[31:INDEX_BITS+2];

   // Fetch lookup: predict taken only on a tag hit whose counter is in a taken state
   always_comb begin
      bp.pred_taken_f  = 1'b0;
      bp.pred_target_f = target_q[index_f];
      if (valid_q[index_f] && (tag_q[index_f] == tag_f)) begin
         bp.pred_taken_f = ctr_q[index_f][1];
      end
   end

   // Redirect when the direction was wrong, or when both said taken but to different targets
   always_comb begin
      mispredict = 1'b0;
      if (bp.update_e) begin
         if (bp.pred_taken_e != bp.branch_taken_e) begin
            mispredict = 1'b1;
         end else if (bp.pred_taken_e && bp.branch_taken_e &&
                      (bp.pred_target_e != bp.target_e)) begin
            mispredict = 1'b1;
         end
      end
   end

   assign bp.mispredict_e = mispredict;
   assign bp.branch_count = branch_count_q;
   assign bp.miss_count   = miss_count_q;

   // Resolve-side tag compare and saturating counter step for a hitting entry
   always_comb begin
      hit_e    = valid_q[index_e] && (tag_q[index_e] == tag_e);
      ctr_next = ctr_q[index_e];
      if (bp.branch_taken_e) begin
         if (ctr_q[index_e] != CTR_STRONG_TAKEN) begin
            ctr_next = ctr_q[index_e] + 2'd1;
         end
      end else begin
         if (ctr_q[index_e] != CTR_STRONG_NOT) begin
            ctr_next = ctr_q[index_e] - 2'd1;
         end
      end
   end

   // Valid bits and direction counters: reset to empty/weakly-not-taken, then train or allocate
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= CTR_WEAK_NOT_TAKEN;
         end
      end else if (bp.update_e) begin
         if (hit_e) begin
            ctr_q[index_e] <= ctr_next;
         end else if (bp.branch_taken_e) begin
            valid_q[index_e] <= 1'b1;
            ctr_q[index_e]   <= CTR_WEAK_TAKEN;
         end
      end
   end

   // Tags and targets carry no reset; any taken resolution either refreshes or allocates the entry
   always_ff @(posedge clk) begin
      if (!rst && bp.update_e && bp.branch_taken_e) begin
         tag_q[index_e]    <= tag_e;
         target_q[index_e] <= bp.target_e;
      end
   end

   // Statistics counters that stick at all-ones instead of wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_count_q <= 32'd0;
         miss_count_q   <= 32'd0;
      end else if (bp.update_e) begin
         if (branch_count_q != COUNT_MAX) begin
            branch_count_q <= branch_count_q + 32'd1;
         end
         if (mispredict && (miss_count_q != COUNT_MAX)) begin
            miss_count_q <= miss_count_q + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor. A small reference model of the
// table and counters produces expected predictions, which are queued when the
// stimulus is driven and popped when the combinational outputs are sampled.
module tb_branch_predictor;

   logic clk;
   logic rst;

   branch_predictor_if bpIf ();

   branch_predictor #(.INDEX_BITS(6)) dut (
      .clk (clk),
      .rst (rst),
      .bp  (bpIf)
   );

   typedef struct {
      logic        predTaken;
      logic [31:0] predTarget;
      logic        mispredict;
   } expect_t;

   expect_t expQ[$];

   int vectorCount    = 0;
   int miscompareCount = 0;

   // Reference model state
   logic        mValid  [64];
   logic [23:0] mTag    [64];
   logic [31:0] mTarget [64];
   logic [1:0]  mCtr    [64];
   logic [31:0] mBranchCount;
   logic [31:0] mMissCount;

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         miscompareCount++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 64; i++) begin
         mValid[i] = 1'b0;
         mCtr[i]   = 2'b01;
      end
      mBranchCount = 32'd0;
      mMissCount   = 32'd0;
   endtask

   task automatic modelPredict(input logic [31:0] pc, output logic taken,
                               output logic [31:0] target);
      int idx;
      idx    = int'(pc[7:2]);
      taken  = mValid[idx] && (mTag[idx] == pc[31:8]) && mCtr[idx][1];
      target = mTarget[idx];
   endtask

   task automatic modelUpdate(input logic [31:0] pc, input logic taken,
                              input logic [31:0] tgt, input logic mis);
      int   idx;
      logic hit;
      idx = int'(pc[7:2]);
      hit = mValid[idx] && (mTag[idx] == pc[31:8]);
      if (hit) begin
         if (taken) begin
            if (mCtr[idx] != 2'b11) mCtr[idx] = mCtr[idx] + 2'd1;
            mTarget[idx] = tgt;
         end else begin
            if (mCtr[idx] != 2'b00) mCtr[idx] = mCtr[idx] - 2'd1;
         end
      end else if (taken) begin
         mValid[idx]  = 1'b1;
         mTag[idx]    = pc[31:8];
         mTarget[idx] = tgt;
         mCtr[idx]    = 2'b10;
      end
      if (mBranchCount != 32'hFFFF_FFFF) mBranchCount = mBranchCount + 32'd1;
      if (mis && (mMissCount != 32'hFFFF_FFFF)) mMissCount = mMissCount + 32'd1;
   endtask

   // One cycle: drive at the falling edge, check combinational outputs just after, train on the rising edge
   task automatic applyStimulus(input logic [31:0] pcF, input logic upd,
                                input logic [31:0] pcE, input logic taken,
                                input logic [31:0] tgt, input logic pTaken,
                                input logic [31:0] pTarget);
      expect_t e;
      expect_t got;
      logic    expTaken;
      logic [31:0] expTarget;
      @(negedge clk);
      bpIf.pc_f           = pcF;
      bpIf.update_e       = upd;
      bpIf.pc_e           = pcE;
      bpIf.branch_taken_e = taken;
      bpIf.target_e       = tgt;
      bpIf.pred_taken_e   = pTaken;
      bpIf.pred_target_e  = pTarget;
      modelPredict(pcF, expTaken, expTarget);
      e.predTaken  = expTaken;
      e.predTarget = expTarget;
      e.mispredict = upd && ((pTaken != taken) || (pTaken && taken && (pTarget != tgt)));
      expQ.push_back(e);
      #1;
      got = expQ.pop_front();
      checkOutput("pred_taken_f", {31'd0, bpIf.pred_taken_f}, {31'd0, got.predTaken});
      if (got.predTaken) begin
         checkOutput("pred_target_f", bpIf.pred_target_f, got.predTarget);
      end
      checkOutput("mispredict_e", {31'd0, bpIf.mispredict_e}, {31'd0, got.mispredict});
      @(posedge clk);
      if (upd) modelUpdate(pcE, taken, tgt, got.mispredict);
      #1;
      checkOutput("branch_count", bpIf.branch_count, mBranchCount);
      checkOutput("miss_count", bpIf.miss_count, mMissCount);
   endtask

   // Resolve a branch whose fetch-time prediction comes from the model, fetching the same PC
   task automatic resolveAt(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
      logic        p;
      logic [31:0] pt;
      modelPredict(pc, p, pt);
      applyStimulus(pc, 1'b1, pc, taken, tgt, p, pt);
   endtask

   task automatic idleAt(input logic [31:0] pcF);
      applyStimulus(pcF, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic checkCtr(input string tag, input int idx);
      checkOutput(tag, {30'd0, dut.ctr_q[idx]}, {30'd0, mCtr[idx]});
   endtask

   // Main sequence
   initial begin
      logic [31:0] pcs [5];
      logic [31:0] pcR;
      logic        p;
      logic [31:0] pt;

      pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h104;
      pcs[3] = 32'h108; pcs[4] = 32'h500;

      rst = 1'b1;
      bpIf.pc_f = 32'h100; bpIf.update_e = 1'b0; bpIf.pc_e = 32'd0;
      bpIf.branch_taken_e = 1'b0; bpIf.target_e = 32'd0;
      bpIf.pred_taken_e = 1'b0; bpIf.pred_target_e = 32'd0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_pred_taken", {31'd0, bpIf.pred_taken_f}, 32'd0);
      checkOutput("reset_mispredict", {31'd0, bpIf.mispredict_e}, 32'd0);
      checkOutput("reset_branch_count", bpIf.branch_count, 32'd0);
      checkOutput("reset_miss_count", bpIf.miss_count, 32'd0);
      checkCtr("reset_ctr", 0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] allocate on taken");
      idleAt(32'h100);
      resolveAt(32'h100, 1'b1, 32'h80);
      idleAt(32'h100);
      checkCtr("alloc_ctr", 0);

      $display("[TB] counter saturation");
      repeat (3) resolveAt(32'h100, 1'b1, 32'h80);
      checkCtr("sat_hi_ctr", 0);
      resolveAt(32'h100, 1'b0, 32'h80);
      idleAt(32'h100);
      checkCtr("st_to_wt_ctr", 0);
      resolveAt(32'h100, 1'b0, 32'h80);
      idleAt(32'h100);
      checkCtr("wt_to_wn_ctr", 0);
      repeat (3) resolveAt(32'h100, 1'b0, 32'h80);
      checkCtr("sat_lo_ctr", 0);

      $display("[TB] alias eviction");
      resolveAt(32'h100, 1'b1, 32'h80);
      idleAt(32'h200);
      resolveAt(32'h200, 1'b1, 32'h40);
      idleAt(32'h100);
      idleAt(32'h200);

      $display("[TB] mispredict cases");
      applyStimulus(32'h0, 1'b1, 32'h108, 1'b1, 32'h80, 1'b0, 32'h0);
      applyStimulus(32'h0, 1'b1, 32'h108, 1'b1, 32'h84, 1'b1, 32'h80);
      applyStimulus(32'h0, 1'b1, 32'h108, 1'b1, 32'h84, 1'b1, 32'h84);
      applyStimulus(32'h0, 1'b1, 32'h108, 1'b0, 32'h84, 1'b0, 32'h84);
      applyStimulus(32'h0, 1'b1, 32'h108, 1'b0, 32'h84, 1'b1, 32'h84);

      $display("[TB] same-cycle read and write");
      resolveAt(32'h104, 1'b1, 32'h60);
      resolveAt(32'h104, 1'b0, 32'h60);
      checkCtr("wn_before_hazard", 1);
      resolveAt(32'h104, 1'b1, 32'h64);
      idleAt(32'h104);

      $display("[TB] random training");
      for (int n = 0; n < 40; n++) begin
         pcR = pcs[$urandom_range(0, 4)];
         modelPredict(pcR, p, pt);
         if ($urandom_range(0, 3) == 0) begin
            p = ~p;
         end
         applyStimulus(pcs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), pcR,
                       1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                       p, pt);
      end

      $display("[TB] asynchronous reset mid-cycle");
      resolveAt(32'h200, 1'b1, 32'h40);
      @(negedge clk);
      bpIf.pc_f = 32'h200; bpIf.update_e = 1'b0;
      #1;
      checkOutput("pre_reset_pred", {31'd0, bpIf.pred_taken_f}, 32'd1);
      #1;
      rst = 1'b1;
      modelReset();
      #1;
      checkOutput("async_reset_pred", {31'd0, bpIf.pred_taken_f}, 32'd0);
      checkOutput("async_reset_branch_count", bpIf.branch_count, 32'd0);
      checkOutput("async_reset_miss_count", bpIf.miss_count, 32'd0);
      bpIf.update_e = 1'b1; bpIf.pc_e = 32'h104; bpIf.branch_taken_e = 1'b1;
      bpIf.target_e = 32'h44; bpIf.pred_taken_e = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("reset_drops_update", bpIf.branch_count, 32'd0);
      @(negedge clk);
      bpIf.update_e = 1'b0;
      rst = 1'b0;
      idleAt(32'h200);
      idleAt(32'h104);
      idleAt(32'h100);

      $display("[TB] counter saturation at all-ones");
      @(negedge clk);
      force dut.branch_count_q = 32'hFFFF_FFFE;
      #1;
      release dut.branch_count_q;
      mBranchCount = 32'hFFFF_FFFE;
      resolveAt(32'h108, 1'b1, 32'h90);
      resolveAt(32'h108, 1'b1, 32'h90);
      checkOutput("branch_count_saturated", bpIf.branch_count, 32'hFFFF_FFFF);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
      $finish;
   end

   // Safety net so the run always terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout required=finish");
      miscompareCount++;
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
